// File: rtl/uart_mmio_regs_pkg.sv
// Shared constants, CSR layout and TX launch states for the UART register block.
package uart_pkg;

   localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
   localparam logic [31:0] UART_CSR_OFS  = 32'h0000_0004;

   localparam int CSR_RX_FULL   = 0;
   localparam int CSR_TX_FULL   = 1;
   localparam int CSR_TX_EMPTY  = 2;
   localparam int CSR_TX_IDLE   = 3;
   localparam int CSR_OVERRUN   = 4;
   localparam int CSR_TX_DROP   = 5;
   localparam int CSR_RX_IRQ_EN = 8;
   localparam int CSR_TX_IRQ_EN = 9;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_e;

   function automatic logic [31:0] csr_pack(
      input logic rx_full,
      input logic tx_full,
      input logic tx_empty,
      input logic tx_idle,
      input logic overrun,
      input logic tx_drop,
      input logic rx_irq_en,
      input logic tx_irq_en
   );
      logic [31:0] w;
      w                = 32'h0000_0000;
      w[CSR_RX_FULL]   = rx_full;
      w[CSR_TX_FULL]   = tx_full;
      w[CSR_TX_EMPTY]  = tx_empty;
      w[CSR_TX_IDLE]   = tx_idle;
      w[CSR_OVERRUN]   = overrun;
      w[CSR_TX_DROP]   = tx_drop;
      w[CSR_RX_IRQ_EN] = rx_irq_en;
      w[CSR_TX_IRQ_EN] = tx_irq_en;
      return w;
   endfunction

endpackage

// File: rtl/uart_mmio_regs_if.sv
// CPU load/store bus into the UART register window.
interface uart_mmio_regs_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wr;
   logic              bus_rd;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_addr, bus_wr, bus_rd, bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  bus_addr, bus_wr, bus_rd, bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with wrap-bit pointers; a push on a full FIFO is taken when a pop frees a slot.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr_q;
   logic [AW:0] rptr_q;
   logic [7:0]  mem_q [DEPTH];
   logic        push_ok_s;
   logic        pop_ok_s;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign dout      = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= {(AW+1){1'b0}};
         rptr_q <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            wptr_q <= wptr_q;
         end
         if (pop_ok_s) begin
            rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            rptr_q <= rptr_q;
         end
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_mmio_regs.sv
// Memory-mapped DATA/CSR registers in front of the UART core: TX FIFO with launch FSM, RX holding register, IRQ.
module uart_mmio_regs
   import uart_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int ADDR_W   = 4
) (
   input  logic            clk,
   input  logic            rst,
   uart_mmio_regs_if.slave bus,
   output logic [7:0]      tx_data,
   output logic            tx_send,
   input  logic            tx_busy,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            irq
);
   tx_state_e   state_q;
   logic [7:0]  tx_data_q;
   logic        tx_send_q;
   logic        irq_q;
   logic [31:0] rdata_q,   rdata_d;
   logic [7:0]  rx_hold_q, rx_hold_d;
   logic        rx_full_q, rx_full_d;
   logic        overrun_q, overrun_d;
   logic        tx_drop_q, tx_drop_d;
   logic        rx_en_q,   rx_en_d;
   logic        tx_en_q,   tx_en_d;

   logic        sel_data_s, sel_csr_s;
   logic        data_wr_s, data_rd_s, csr_wr_s;
   logic        fifo_full_s, fifo_empty_s, fifo_pop_s;
   logic [7:0]  fifo_dout_s;
   logic        tx_idle_s;
   logic [31:0] csr_s;
   logic        unused_s;

   assign sel_data_s = (bus.bus_addr[ADDR_W-1:2] == UART_DATA_OFS[ADDR_W-1:2]);
   assign sel_csr_s  = (bus.bus_addr[ADDR_W-1:2] == UART_CSR_OFS[ADDR_W-1:2]);
   assign data_wr_s  = bus.bus_wr & sel_data_s;
   assign data_rd_s  = bus.bus_rd & sel_data_s;
   assign csr_wr_s   = bus.bus_wr & sel_csr_s;
   assign fifo_pop_s = (state_q == IDLE) & ~fifo_empty_s;
   assign tx_idle_s  = fifo_empty_s & (state_q == IDLE);
   assign csr_s      = csr_pack(rx_full_q, fifo_full_s, fifo_empty_s, tx_idle_s,
                                overrun_q, tx_drop_q, rx_en_q, tx_en_q);
   assign unused_s   = ^{bus.bus_wdata[31:10], bus.bus_addr[1:0]};

   uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_wr_s),
      .pop   (fifo_pop_s),
      .din   (bus.bus_wdata[7:0]),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Register next-state: read mux, CSR writes, then RX capture so a same-cycle set beats a W1C clear.
   always_comb begin
      rdata_d   = rdata_q;
      rx_hold_d = rx_hold_q;
      rx_full_d = rx_full_q;
      overrun_d = overrun_q;
      tx_drop_d = tx_drop_q;
      rx_en_d   = rx_en_q;
      tx_en_d   = tx_en_q;

      if (bus.bus_rd) begin
         if (sel_data_s) begin
            rdata_d = {24'h00_0000, rx_hold_q};
         end else if (sel_csr_s) begin
            rdata_d = csr_s;
         end else begin
            rdata_d = 32'h0000_0000;
         end
      end else begin
         rdata_d = rdata_q;
      end

      if (csr_wr_s) begin
         rx_en_d = bus.bus_wdata[CSR_RX_IRQ_EN];
         tx_en_d = bus.bus_wdata[CSR_TX_IRQ_EN];
         if (bus.bus_wdata[CSR_OVERRUN]) begin
            overrun_d = 1'b0;
         end else begin
            overrun_d = overrun_q;
         end
         if (bus.bus_wdata[CSR_TX_DROP]) begin
            tx_drop_d = 1'b0;
         end else begin
            tx_drop_d = tx_drop_q;
         end
      end else begin
         rx_en_d = rx_en_q;
         tx_en_d = tx_en_q;
      end

      if (data_wr_s && fifo_full_s && !fifo_pop_s) begin
         tx_drop_d = 1'b1;
      end else begin
         tx_drop_d = tx_drop_d;
      end

      if (rx_valid && data_rd_s) begin
         rx_hold_d = rx_data;
         rx_full_d = 1'b1;
      end else if (rx_valid) begin
         if (!rx_full_q) begin
            rx_hold_d = rx_data;
            rx_full_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (data_rd_s) begin
         rx_full_d = 1'b0;
      end else begin
         rx_full_d = rx_full_q;
      end
   end

   // Register state update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q   <= 32'h0000_0000;
         rx_hold_q <= 8'h00;
         rx_full_q <= 1'b0;
         overrun_q <= 1'b0;
         tx_drop_q <= 1'b0;
         rx_en_q   <= 1'b0;
         tx_en_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         rdata_q   <= rdata_d;
         rx_hold_q <= rx_hold_d;
         rx_full_q <= rx_full_d;
         overrun_q <= overrun_d;
         tx_drop_q <= tx_drop_d;
         rx_en_q   <= rx_en_d;
         tx_en_q   <= tx_en_d;
         irq_q     <= (rx_full_q & rx_en_q) | (tx_idle_s & tx_en_q);
      end
   end

   // TX launch FSM; tx_send is high exactly while in SEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty_s) begin
                  tx_data_q <= fifo_dout_s;
                  tx_send_q <= 1'b1;
                  state_q   <= SEND;
               end else begin
                  tx_send_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            SEND: begin
               tx_send_q <= 1'b0;
               state_q   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               tx_send_q <= 1'b0;
               if (tx_busy) begin
                  state_q <= WAIT_DONE;
               end else begin
                  state_q <= WAIT_BUSY;
               end
            end
            WAIT_DONE: begin
               tx_send_q <= 1'b0;
               if (!tx_busy) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT_DONE;
               end
            end
            default: begin
               tx_send_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign bus.bus_rdata = rdata_q;
   assign tx_data       = tx_data_q;
   assign tx_send       = tx_send_q;
   assign irq           = irq_q;

endmodule
